// File: rtl/ex_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Remainder goes to hi, quotient to lo; stalls the pipe while busy.
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        signed_div,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_stall,
  input  logic        cancel,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        ge;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Magnitudes only when signed; 0x80000000 maps to itself (2^31).
  assign a_mag = (signed_div && src_a[31]) ? -src_a : src_a;
  assign b_mag = (signed_div && src_b[31]) ? -src_b : src_b;

  always_comb begin
    rem_sh = {rem_q, dvd_q[31]};
    ge     = rem_sh >= {1'b0, dvs_q};
    diff   = rem_sh[31:0] - dvs_q;
    rem_d  = ge ? diff : rem_sh[31:0];
    quo_d  = {quo_q[30:0], ge};
    hi_d   = neg_r_q ? -rem_d : rem_d;
    lo_d   = neg_q_q ? -quo_d : quo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (cancel) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en) begin
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q_q <= signed_div & (src_a[31] ^ src_b[31]);
            neg_r_q <= signed_div & src_a[31];
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            cnt_q   <= 5'd0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= {dvd_q[30:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Result is held until EX advances.
          if (!ex_stall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_req = ((state_q == S_IDLE && en) ||
                      state_q == S_BUSY) && !cancel;
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: cycle model plus
// directed vectors with hand-computed results.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        signed_div;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ex_stall;
  logic        cancel;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  ex_div_unit dut (
    .clk(clk), .rst(rst), .en(en), .signed_div(signed_div),
    .src_a(src_a), .src_b(src_b), .ex_stall(ex_stall),
    .cancel(cancel), .stall_req(stall_req), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for one divide.
  function automatic void ref_div(input bit s,
      input logic [31:0] a, input logic [31:0] b,
      output logic [31:0] h, output logic [31:0] l);
    if (!s) begin
      if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
      else begin l = a / b; h = a % b; end
    end else if (b == 0) begin
      l = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      h = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      l = 32'h8000_0000; h = 32'd0;
    end else begin
      l = $signed(a) / $signed(b);
      h = $signed(a) % $signed(b);
    end
  endfunction

  // Cycle-level model: 0 idle, 1 busy, 2 done.
  int          m_ph = 0;
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_hi = 0; m_lo = 0;
    end else if (cancel) begin
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (en) begin
        ref_div(signed_div, src_a, src_b, p_hi, p_lo);
        m_ph = 1; m_left = 32;
      end
    end else if (m_ph == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_ph = 2; m_hi = p_hi; m_lo = p_lo;
      end
    end else if (!ex_stall) begin
      m_ph = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_stall", {31'd0, stall_req},
          {31'd0, ((m_ph == 0 && en) || m_ph == 1) && !cancel});
      chk("m_done", {31'd0, done}, {31'd0, m_ph == 2});
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
    end
  end

  task automatic start_op(input bit s, input logic [31:0] a,
                          input logic [31:0] b);
    signed_div = s; src_a = a; src_b = b; en = 1'b1;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    if (!done) begin
      errors++;
      $display("FAIL %s: timeout waiting for done", nm);
    end
  endtask

  task automatic run(input string nm, input bit s,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] el, input logic [31:0] eh);
    int n;
    @(posedge clk); #1;
    start_op(s, a, b);
    wait_done(nm, n);
    en = 1'b0;
    chk({nm, "_lat"}, n, 33);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_hi"}, hi, eh);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; signed_div = 1'b0; src_a = 0; src_b = 0;
    ex_stall = 1'b0; cancel = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_stall", {31'd0, stall_req}, 0);

    run("divu_100_7", 0, 100, 7, 14, 2);
    run("div_m7_2", 1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("div_7_m2", 1, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1);
    run("divu_5_0", 0, 5, 0, 32'hFFFF_FFFF, 5);
    run("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("div_m7_0", 1, 32'hFFFF_FFF9, 0, 1, 32'hFFFF_FFF9);

    // Back-to-back: en kept high through DONE, new start one cycle later.
    @(posedge clk); #1;
    start_op(0, 1000, 10);
    wait_done("b2b_a", n);
    chk("b2b_a_lo", lo, 100);
    src_a = 50; src_b = 5;
    #1 chk("b2b_done_nostall", {31'd0, stall_req}, 0);
    wait_done("b2b_b", n);
    en = 1'b0;
    chk("b2b_b_lat", n, 34);
    chk("b2b_b_lo", lo, 10);
    chk("b2b_b_hi", hi, 0);

    // Cancel in the start cycle leaves the unit idle.
    @(posedge clk); #1;
    start_op(0, 40, 3); cancel = 1'b1;
    #1 chk("cstart_stall", {31'd0, stall_req}, 0);
    @(posedge clk); #1;
    en = 1'b0; cancel = 1'b0;
    #1 chk("cstart_idle", {31'd0, stall_req}, 0);

    // Cancel at BUSY cycle 10, then restart immediately.
    @(posedge clk); #1;
    start_op(0, 100, 7);
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_stall", {31'd0, stall_req}, 0);
    chk("cancel_done", {31'd0, done}, 0);
    chk("cancel_lo_kept", lo, 10);
    chk("cancel_hi_kept", hi, 0);
    start_op(0, 9, 3);
    wait_done("after_cancel", n);
    en = 1'b0;
    chk("after_cancel_lat", n, 33);
    chk("after_cancel_lo", lo, 3);
    chk("after_cancel_hi", hi, 0);

    // Held in DONE by ex_stall with en still high.
    @(posedge clk); #1;
    start_op(0, 81, 9);
    wait_done("hold", n);
    ex_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_done", {31'd0, done}, 1);
      chk("hold_nostall", {31'd0, stall_req}, 0);
      chk("hold_lo", lo, 9);
      chk("hold_hi", hi, 0);
    end
    ex_stall = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("hold_release", {31'd0, done}, 0);

    // Reset at BUSY cycle 20.
    @(posedge clk); #1;
    start_op(0, 100, 7);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_hi", hi, 0);
    chk("mrst_lo", lo, 0);
    chk("mrst_done", {31'd0, done}, 0);
    chk("mrst_stall", {31'd0, stall_req}, 0);
    run("divu_big", 0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Multi-cycle 32-bit integer divider for the EX stage; implements DIV/DIVU. It is a stall requester for the pipeline controller: it raises `stall_req` while a division is in flight, so the controller holds the EX and earlier stages. It also accepts the controller's cancel, driven from `exception_flush | mem_refetch`, to abandon work on squashed instructions. HI receives the remainder and LO the quotient, written to the HI/LO path when the EX stage advances.

## Interface
- No parameters; data width fixed at 32.
- `clk  input  1  clock; all state updates on rising edge`
- `rst  input  1  reset, synchronous, active-high`
- `en  input  1  valid DIV/DIVU instruction present in EX`
- `signed_div  input  1  1 = DIV (two's complement), 0 = DIVU`
- `src_a  input  32  dividend`
- `src_b  input  32  divisor`
- `ex_stall  input  1  stall on EX from other sources (d-cache, TLB), excluding this block's own request`
- `cancel  input  1  exception flush or mem refetch; kills the current operation`
- `stall_req  output  1  division in progress; hold EX (fed to the controller as a stall request)`
- `done  output  1  result valid on hi/lo this cycle`
- `hi  output  32  remainder`
- `lo  output  32  quotient`

## Operation
- **States:** IDLE, BUSY, DONE. Iteration counter is 5 bits, running 0..31.
- **IDLE:**
  - When `en=1` and `cancel=0`:
    - latch |src_a| and |src_b|, using magnitudes only if `signed_div=1`;
    - latch quotient sign = a[31]^b[31] and remainder sign = a[31], both when signed;
    - clear the partial remainder and the counter;
    - go to BUSY.
- **BUSY:** one restoring-division step per cycle.
  - Compute `rem' = {rem[31:0], dvd[31]}` as 33 bits and shift the dividend left.
  - If `rem' >= {1'b0, divisor}`: subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - At count 31, apply the sign fixup (two's-complement negate where the sign flag is set), register the results to `hi`/`lo`, and go to DONE.
- **DONE:** `done=1` and `hi`/`lo` are held.
  - `ex_stall=0`: go to IDLE next cycle, because the instruction leaves EX.
  - `ex_stall=1`: stay in DONE, with no restart and no recompute.
- **`stall_req`** = `((IDLE & en) | BUSY) & ~cancel`. This is combinational so the start cycle already stalls.
- **Cancel:** `cancel=1` in any state forces IDLE next cycle. `hi`/`lo` are unchanged and `done` goes to 0. Priority is `rst` > `cancel` > normal flow.
- **Divide by zero** (architecturally UNPREDICTABLE, but fixed here for determinism):
  - magnitude quotient = 0xFFFFFFFF and magnitude remainder = |dividend|, as produced naturally by the algorithm;
  - the sign fixup is then applied.
- **Overflow** (0x80000000 / -1, signed): the magnitude path yields quotient 0x80000000 and remainder 0. No trap is raised.
- `en` is only sampled in IDLE. Operand changes during BUSY/DONE are ignored.

## Timing
- **Reset:** state = IDLE, counter = 0; `stall_req=0`, `done=0`, `hi=0`, `lo=0`.
- **Start:** cycle T (IDLE, `en=1`) has `stall_req=1`. Cycles T+1..T+32 are BUSY with `stall_req=1`.
- **Result:** cycle T+33 is DONE with `stall_req=0` and `done=1`, and `hi`/`lo` are valid.
  - The stall lasts exactly 33 cycles.
  - The result is consumed when the EX stage advances at the end of T+33, provided `ex_stall=0`.
- **Back-to-back divides:** DONE at T+33 returns to IDLE at T+34. The next divide's start cycle is T+34, so there is one non-stall cycle between two divides.
- **Cancel in the start cycle:** no state change, and `stall_req=0` that cycle.
- **`rst` mid-BUSY:** IDLE on the next edge, and all outputs return to their reset values.

## Test plan
- **DIVU:** src_a=100, src_b=7 → `stall_req` high for 33 cycles; at DONE, lo=14 and hi=2 with `done=1`.
- **DIV, signs:** src_a=-7 (0xFFFFFFF9), src_b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also src_a=7, src_b=-2 → lo=-3, hi=1.
- **Zero and overflow:**
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- **Cancel:** assert `cancel` at BUSY cycle 10.
  - Next cycle: IDLE, `stall_req=0`, previous `hi`/`lo` retained.
  - A new DIVU 9/3 started immediately completes 33 cycles later with lo=3, hi=0.
- **Held in DONE:** hold `ex_stall=1` for 5 cycles after DONE with `en` still high.
  - Stays in DONE, `done=1`, results stable, no second stall.
  - Drop `ex_stall` → IDLE the following cycle.
- **Reset mid-op:** assert `rst` at BUSY cycle 20 → all outputs 0 next cycle. A subsequent DIVU 0xFFFFFFFF/0x10 gives lo=0x0FFFFFFF, hi=0xF.
